gf_inv_sequencer: RTL

Iterative controller that computes the AES S-box byte for the subBytes stage. It sequences one shared bit-serial GF(2^8) multiply/reduce datapath, modulo POLY, through a fixed square-and-multiply schedule that evaluates a^254 (the multiplicative inverse, with 0 mapping to 0). It then optionally applies the AES affine transform. A valid/ready handshake sits on both sides, so the block can be placed between the key/state buffer and the subBytes output register.

---
 rtl/gf_inv_sequencer_if.sv | 20 ++
 rtl/gf_inv_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/gf_inv_sequencer_if.sv
// Byte handshake bundle for the S-box sequencer.
// master drives bytes in and takes results; slave is the sequencer.
interface gf_inv_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/gf_inv_sequencer.sv
// AES S-box via a^254 on one bit-serial GF(2^8) multiplier.
// 13 ops (square/multiply alternating) x 8 bits, then optional affine.
module gf_inv_sequencer #(
   parameter logic [8:0] POLY      = 9'h11B,
   parameter bit         AFFINE_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   gf_inv_sequencer_if.slave io,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] base_q, r_q, acc_q, out_q;
   logic [3:0] op_q;
   logic [2:0] bit_q;
   logic       ov_q;

   logic [7:0] y, acc_cur, acc_nx;
   logic       accept, last_step;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? POLY[7:0] : 8'h00);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v,
                                       input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] out_map(input logic [7:0] b);
      if (AFFINE_EN)
         return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
                  ^ rotl(b, 4) ^ 8'h63;
      else
         return b;
   endfunction

   // One multiplier step: even ops square r, odd ops multiply by base
   always_comb begin
      y         = op_q[0] ? base_q : r_q;
      acc_cur   = (bit_q == 3'd7) ? 8'h00 : acc_q;
      acc_nx    = xtime(acc_cur) ^ (y[bit_q] ? r_q : 8'h00);
      accept    = (state_q == IDLE) && io.in_valid;
      last_step = (bit_q == 3'd0) && (op_q == 4'd12);
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (io.in_valid) state_d = MUL;
         MUL:  if (last_step) state_d = DONE;
         DONE: if (io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand, accumulator and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         r_q    <= '0;
         acc_q  <= '0;
         out_q  <= '0;
         op_q   <= '0;
         bit_q  <= '0;
         ov_q   <= 1'b0;
      end else begin
         if (accept) begin
            base_q <= io.in_data;
            r_q    <= io.in_data;
            op_q   <= 4'd0;
            bit_q  <= 3'd7;
         end
         if (state_q == MUL) begin
            acc_q <= acc_nx;
            if (bit_q == 3'd0) begin
               r_q   <= acc_nx;
               bit_q <= 3'd7;
               op_q  <= op_q + 4'd1;
               if (op_q == 4'd12) begin
                  out_q <= out_map(acc_nx);
                  ov_q  <= 1'b1;
               end
            end else begin
               bit_q <= bit_q - 3'd1;
            end
         end
         if (state_q == DONE && io.out_ready) ov_q <= 1'b0;
      end
   end

   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = ov_q;
   assign io.out_data  = out_q;
   assign busy         = (state_q == MUL);

endmodule
